// File: rtl/serial_subtractor_5_bit.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first, start/busy/done handshake.
// Optional macro SUB_OVF_EN adds the OVF output (two's-complement overflow of the last result).
module serial_subtractor_5_bit #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bout
`ifdef SUB_OVF_EN
   ,
   output logic             OVF
`endif
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] res_sh_r;
   logic             borrow_r;
   logic [CW-1:0]    cnt_r;
   logic [1:0]       fs_s;
   logic [WIDTH-1:0] res_nxt_s;

   // Full-subtractor cell: returns {borrow_out, diff}.
   function automatic logic [1:0] fsub(input logic a, input logic b, input logic br);
      logic d;
      logic bo;
      d  = a ^ b ^ br;
      bo = (~a & b) | (~(a ^ b) & br);
      return {bo, d};
   endfunction

   // Current bit through the subtractor cell and the result word it would complete.
   always_comb begin
      fs_s      = fsub(a_sh_r[0], b_sh_r[0], borrow_r);
      res_nxt_s = {fs_s[0], res_sh_r[WIDTH-1:1]};
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_nxt_s = RUN;
            else       state_nxt_s = IDLE;
         end
         RUN: begin
            if (cnt_r == LAST) state_nxt_s = DONE;
            else               state_nxt_s = RUN;
         end
         DONE: begin
            if (start) state_nxt_s = RUN;
            else       state_nxt_s = IDLE;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_nxt_s;
   end

   // Operand shifters, borrow FF, bit counter and registered result/handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh_r   <= '0;
         b_sh_r   <= '0;
         res_sh_r <= '0;
         borrow_r <= 1'b0;
         cnt_r    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         D        <= '0;
         Bout     <= 1'b0;
`ifdef SUB_OVF_EN
         OVF      <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  a_sh_r   <= A;
                  b_sh_r   <= B;
                  borrow_r <= Bin;
                  res_sh_r <= '0;
                  cnt_r    <= '0;
               end
            end
            RUN: begin
               a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
               b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
               res_sh_r <= res_nxt_s;
               borrow_r <= fs_s[1];
               cnt_r    <= cnt_r + ONE;
               if (cnt_r == LAST) begin
                  D    <= res_nxt_s;
                  Bout <= fs_s[1];
`ifdef SUB_OVF_EN
                  // borrow_r is the borrow into the MSB at this last step
                  OVF  <= borrow_r ^ fs_s[1];
`endif
               end
            end
            default: ;
         endcase
         busy <= (state_nxt_s == RUN);
         done <= (state_nxt_s == DONE);
      end
   end

endmodule

// File: tb/tb_serial_subtractor_5_bit.sv
// Directed self-checking bench for serial_subtractor_5_bit (OVF checks only when SUB_OVF_EN is defined).
module tb_serial_subtractor_5_bit;

   logic       clk;
   logic       rst;
   logic       start;
   logic [4:0] A;
   logic [4:0] B;
   logic       Bin;
   logic       busy;
   logic       done;
   logic [4:0] D;
   logic       Bout;
`ifdef SUB_OVF_EN
   logic       OVF;
`endif

   int checks;
   int errors;

   serial_subtractor_5_bit #(.WIDTH(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .busy  (busy),
      .done  (done),
      .D     (D),
      .Bout  (Bout)
`ifdef SUB_OVF_EN
      ,
      .OVF   (OVF)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation and wait for done; cyc = -1 if done never arrives.
   task automatic run_op(input logic [4:0] a, input logic [4:0] b, input logic bi,
                         output int cyc, output int bcnt);
      A = a; B = b; Bin = bi; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      bcnt = 0;
      while (done !== 1'b1 && cyc < 20) begin
         if (busy === 1'b1) bcnt++;
         tick();
         cyc++;
      end
      if (done !== 1'b1) cyc = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; A = 5'd0; B = 5'd0; Bin = 1'b0;
      #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (D !== 5'd0) begin errors++; $display("FAIL reset_d got %0d want 0", D); end
      checks++; if (Bout !== 1'b0) begin errors++; $display("FAIL reset_bout got %b want 0", Bout); end
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int cyc, bcnt;
      run_op(5'd9, 5'd3, 1'b0, cyc, bcnt);
      checks++; if (cyc !== 5) begin errors++; $display("FAIL basic_latency got %0d want 5", cyc); end
      checks++; if (bcnt !== 5) begin errors++; $display("FAIL basic_busy_cycles got %0d want 5", bcnt); end
      checks++; if (D !== 5'd6) begin errors++; $display("FAIL basic_d got %0d want 6", D); end
      checks++; if (Bout !== 1'b0) begin errors++; $display("FAIL basic_bout got %b want 0", Bout); end
`ifdef SUB_OVF_EN
      checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", OVF); end
`endif
      tick(); tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_flags got done=%b busy=%b want 0 0", done, busy); end
      checks++; if (D !== 5'd6) begin errors++; $display("FAIL idle_hold_d got %0d want 6", D); end
   endtask

   task automatic test_negative();
      int cyc, bcnt;
      run_op(5'd3, 5'd9, 1'b0, cyc, bcnt);
      checks++; if (cyc !== 5) begin errors++; $display("FAIL neg_latency got %0d want 5", cyc); end
      checks++; if (D !== 5'd26) begin errors++; $display("FAIL neg_d got %0d want 26", D); end
      checks++; if (Bout !== 1'b1) begin errors++; $display("FAIL neg_bout got %b want 1", Bout); end
`ifdef SUB_OVF_EN
      checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL neg_ovf got %b want 0", OVF); end
`endif
      tick();
   endtask

   task automatic test_edges();
      int cyc, bcnt;
      run_op(5'd7, 5'd7, 1'b0, cyc, bcnt);
      checks++; if (D !== 5'd0) begin errors++; $display("FAIL equal_d got %0d want 0", D); end
      checks++; if (Bout !== 1'b0) begin errors++; $display("FAIL equal_bout got %b want 0", Bout); end
      tick();
      run_op(5'd0, 5'd0, 1'b1, cyc, bcnt);
      checks++; if (D !== 5'd31) begin errors++; $display("FAIL wrap_d got %0d want 31", D); end
      checks++; if (Bout !== 1'b1) begin errors++; $display("FAIL wrap_bout got %b want 1", Bout); end
`ifdef SUB_OVF_EN
      checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %b want 0", OVF); end
`endif
      tick();
   endtask

   task automatic test_mid_reset();
      int cyc, bcnt;
      int saw_done;
      A = 5'd20; B = 5'd5; Bin = 1'b0; start = 1'b1;
      tick();
      A = 5'd9; B = 5'd27;
      tick();
      A = 5'd1; B = 5'd2;
      tick();
      #3;
      rst = 1'b1;
      start = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
      checks++; if (D !== 5'd0) begin errors++; $display("FAIL midrst_d got %0d want 0", D); end
      checks++; if (Bout !== 1'b0) begin errors++; $display("FAIL midrst_bout got %b want 0", Bout); end
      tick(); tick();
      rst = 1'b0;
      saw_done = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) saw_done++;
      end
      checks++; if (saw_done !== 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles want 0", saw_done); end
      run_op(5'd20, 5'd5, 1'b0, cyc, bcnt);
      checks++; if (cyc !== 5) begin errors++; $display("FAIL fresh_latency got %0d want 5", cyc); end
      checks++; if (D !== 5'd15) begin errors++; $display("FAIL fresh_d got %0d want 15", D); end
      checks++; if (Bout !== 1'b0) begin errors++; $display("FAIL fresh_bout got %b want 0", Bout); end
      tick();
   endtask

   task automatic test_back_to_back();
      int cyc, bcnt;
      int gap;
      run_op(5'd31, 5'd31, 1'b0, cyc, bcnt);
      checks++; if (D !== 5'd0) begin errors++; $display("FAIL b2b_first_d got %0d want 0", D); end
      checks++; if (Bout !== 1'b0) begin errors++; $display("FAIL b2b_first_bout got %b want 0", Bout); end
      A = 5'd16; B = 5'd1; Bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      gap = 1;
      while (done !== 1'b1 && gap < 20) begin
         tick();
         gap++;
      end
      checks++; if (gap !== 6) begin errors++; $display("FAIL b2b_gap got %0d want 6", gap); end
      checks++; if (D !== 5'd15) begin errors++; $display("FAIL b2b_second_d got %0d want 15", D); end
      checks++; if (Bout !== 1'b0) begin errors++; $display("FAIL b2b_second_bout got %b want 0", Bout); end
`ifdef SUB_OVF_EN
      checks++; if (OVF !== 1'b1) begin errors++; $display("FAIL b2b_ovf got %b want 1", OVF); end
`endif
      tick();
   endtask

   task automatic test_ovf();
      int cyc, bcnt;
      run_op(5'd15, 5'd16, 1'b0, cyc, bcnt);
      checks++; if (D !== 5'd31) begin errors++; $display("FAIL ovf_d got %0d want 31", D); end
      checks++; if (Bout !== 1'b1) begin errors++; $display("FAIL ovf_bout got %b want 1", Bout); end
`ifdef SUB_OVF_EN
      checks++; if (OVF !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", OVF); end
`endif
      tick();
      run_op(5'd5, 5'd2, 1'b0, cyc, bcnt);
      checks++; if (D !== 5'd3) begin errors++; $display("FAIL noovf_d got %0d want 3", D); end
`ifdef SUB_OVF_EN
      checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL noovf_flag got %b want 0", OVF); end
`endif
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_negative();
      test_edges();
      test_mid_reset();
      test_back_to_back();
      test_ovf();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor_5_bit.md
Name: serial_subtractor_5_bit

Overview:
Bit-serial, multi-cycle subtractor that is the inverse operation of the team's ripple adder chain. It computes D = A - B - Bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It trades latency for area in datapaths where a 5-bit result every WIDTH+1 cycles is sufficient. A start/busy/done handshake gives it a sequential interface.

Parameters:
WIDTH, 5, operand and result width in bits (must be at least 2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled on a rising clk edge when state is IDLE or DONE
A  input  WIDTH  minuend; sampled with start
B  input  WIDTH  subtrahend; sampled with start
Bin  input  1  borrow-in; sampled with start
busy  output  1  high while the state is RUN
done  output  1  one-cycle pulse; D and Bout are valid from this cycle onward
D  output  WIDTH  difference register; holds the last result
Bout  output  1  final borrow-out; 1 iff A < B + Bin (unsigned)

Behaviour:
- Reset: rst high forces all of the following immediately, regardless of clk:
  - state = IDLE
  - busy = 0, done = 0, D = 0, Bout = 0 (OVF = 0 if present)
  - shift registers, borrow FF and bit counter all cleared
- Reset applied mid-operation abandons the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE: busy = 0, done = 0. On start = 1 at an edge:
  - latch A, B and Bin into internal registers (borrow FF <- Bin)
  - counter <- 0; next state = RUN
- RUN: busy = 1. Each edge processes bit a = a_sh[0], b = b_sh[0], br = borrow FF:
  - diff bit = a ^ b ^ br
  - borrow FF <- (~a & b) | (~(a ^ b) & br)
  - the diff bit shifts into the MSB of the result shift register; a_sh and b_sh shift right
  - counter increments
  - at the edge where counter reaches WIDTH-1: D <- completed result, Bout <- final borrow, next state = DONE
- DONE: done = 1 and busy = 0 for exactly one cycle.
  - start = 1 at this edge begins a new operation (next state RUN, operands latched); otherwise next state = IDLE.
- Latency: start sampled at edge 0 gives done = 1 in the cycle between edge WIDTH and edge WIDTH+1. Back-to-back throughput is one result per WIDTH+1 cycles.
- start during RUN is ignored; A, B and Bin may change freely during RUN.
- D and Bout change only on entry to DONE (or on reset). They hold through IDLE and through the following RUN.
- Arithmetic: modulo 2^WIDTH. D = (A - B - Bin) mod 2^WIDTH. Edge cases:
  - A = B with Bin = 0 gives D = 0, Bout = 0.
  - A = 0, B = 0, Bin = 1 wraps to all ones with Bout = 1.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
Macro: SUB_OVF_EN.
- Defined: an extra output port OVF (1 bit) exists. It is updated together with D on entry to DONE, and cleared by reset. OVF = 1 iff two's-complement signed overflow occurred, i.e. the borrow into the MSB XOR the borrow out of the MSB.
- Not defined: no OVF port and no related logic. All other behaviour is identical.

Test Plan:
1. Reset, then A=9, B=3, Bin=0, start for one cycle. Required: busy=1 for 5 cycles, then done=1 for one cycle with D=6, Bout=0, OVF=0. D stays 6 in IDLE.
2. A=3, B=9, Bin=0. Required: D=26 (5'b11010), Bout=1, OVF=0.
3. A=0, B=0, Bin=1 (wrap). Required: D=31, Bout=1, OVF=0. Then A=7, B=7, Bin=0 gives D=0, Bout=0.
4. Start A=20, B=5; hold start high through RUN while changing A and B. Assert rst asynchronously between edge 2 and edge 3. Required: busy, done, D and Bout are 0 immediately; no done pulse. A fresh start with A=20, B=5 then yields D=15, Bout=0.
5. Back-to-back: A=31, B=31, then start held in the DONE cycle with A=16, B=1. Required:
   - first done with D=0, Bout=0
   - second done exactly 6 cycles later with D=15, Bout=0, OVF=1 (-16 - 1 overflows)
6. OVF check (SUB_OVF_EN): A=15, B=16, Bin=0. Required: D=31, Bout=1, OVF=1. Then A=5, B=2 gives D=3, OVF=0. Recompile without the macro and rerun scenarios 1-3: D and Bout must be unchanged.
